// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream: re-encodes a one-hot word to its binary index behind a registered valid/ready stage,
// flagging malformed words and keeping a saturating count of them.
module onehot_encoder_stream #(
    parameter int WIDTH = 16,
    localparam int BIN_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] one_hot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] binary,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);
    logic [BIN_W-1:0] idx;
    logic bad, accept;
    assign in_ready = rst_n && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign bad = ~|one_hot || |(one_hot & (one_hot - 1'b1));
    // Scan downward so the lowest set bit wins on multi-hot words.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (one_hot[i]) idx = i[BIN_W-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            binary <= '0;
            err <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                binary <= idx;
                err <= bad;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && bad && err_count != '1) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream: randomized and directed stimulus checked against a behavioural model of the encoder.
module tb_onehot_encoder_stream;
    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready;
    logic [15:0] one_hot;
    logic in_ready, out_valid, err;
    logic [3:0] binary;
    logic [7:0] err_count;
    int total = 0, bad = 0;
    bit mv, me, last_acc;
    logic [3:0] mb;
    int mc;
    logic [3:0] got_q[$];

    onehot_encoder_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .one_hot(one_hot),
        .out_valid(out_valid), .out_ready(out_ready), .binary(binary), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Lowest set bit isolated arithmetically, then its position by log2.
    function automatic logic [3:0] ref_idx(logic [15:0] x);
        logic [15:0] l;
        l = x & (~x + 16'd1);
        return (x == 16'd0) ? 4'd0 : 4'($clog2(l));
    endfunction

    function automatic bit ref_bad(logic [15:0] x);
        return $countones(x) != 1;
    endfunction

    task automatic tick(input logic rn, input logic v, input logic [15:0] oh, input logic ordy);
        bit acc;
        @(negedge clk);
        total++;
        if (out_valid !== mv) begin bad++; $display("FAIL out_valid got=%0b exp=%0b t=%0t", out_valid, mv, $time); end
        total++;
        if (err_count !== 8'(mc)) begin bad++; $display("FAIL err_count got=%0d exp=%0d t=%0t", err_count, mc, $time); end
        if (mv) begin
            total++;
            if (binary !== mb || err !== me) begin
                bad++;
                $display("FAIL result got=%0d/%0b exp=%0d/%0b t=%0t", binary, err, mb, me, $time);
            end
        end
        rst_n = rn; in_valid = v; one_hot = oh; out_ready = ordy;
        #1;
        acc = rn && v && (!mv || ordy);
        total++;
        if (in_ready !== (rn && (!mv || ordy))) begin
            bad++;
            $display("FAIL in_ready got=%0b exp=%0b t=%0t", in_ready, rn && (!mv || ordy), $time);
        end
        if (out_valid && out_ready) got_q.push_back(binary);
        last_acc = acc;
        @(posedge clk);
        if (!rn) begin mv = 0; mb = 0; me = 0; mc = 0; end
        else if (acc) begin
            mv = 1; mb = ref_idx(oh); me = ref_bad(oh);
            if (me && mc < 255) mc++;
        end else if (ordy) mv = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 1; one_hot = 16'h0004; out_ready = 1;
        repeat (2) @(posedge clk);
        mv = 0; mb = 0; me = 0; mc = 0;
        #1;
        total++;
        if (binary !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL reset_regs got=%0d/%0b exp=0/0", binary, err); end
        repeat (2) tick(0, 1, 16'h0004, 1);
        tick(1, 1, 16'h0004, 1);
        #1;
        total++;
        if (out_valid !== 1'b1 || binary !== 4'd2 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got=%0b/%0d/%0b exp=1/2/0", out_valid, binary, err);
        end
        tick(1, 0, 16'h0000, 1);
    endtask

    task automatic test_stream();
        logic [15:0] ins[5] = '{16'h0001, 16'h0002, 16'h0080, 16'h1000, 16'h8000};
        logic [3:0] exp[5] = '{4'd0, 4'd1, 4'd7, 4'd12, 4'd15};
        got_q.delete();
        foreach (ins[i]) tick(1, 1, ins[i], 1);
        tick(1, 0, 16'h0000, 1);
        tick(1, 0, 16'h0000, 1);
        total++;
        if (got_q.size() != 5) begin bad++; $display("FAIL stream_count got=%0d exp=5", got_q.size()); end
        else foreach (exp[i]) begin
            total++;
            if (got_q[i] !== exp[i]) begin bad++; $display("FAIL stream[%0d] got=%0d exp=%0d", i, got_q[i], exp[i]); end
        end
    endtask

    task automatic test_malformed();
        int c0;
        c0 = mc;
        tick(1, 1, 16'h0000, 1);
        tick(1, 1, 16'h0014, 1);
        tick(1, 1, 16'hFFFF, 1);
        #1;
        total++;
        if (binary !== 4'd0 || err !== 1'b1) begin bad++; $display("FAIL malformed_ffff got=%0d/%0b exp=0/1", binary, err); end
        total++;
        if (err_count !== 8'(c0 + 3)) begin bad++; $display("FAIL malformed_cnt got=%0d exp=%0d", err_count, c0 + 3); end
        tick(1, 0, 16'h0000, 1);
    endtask

    task automatic test_stall();
        got_q.delete();
        tick(1, 1, 16'h0020, 1);
        repeat (3) begin
            tick(1, 1, 16'h0200, 0);
            #1;
            total++;
            if (binary !== 4'd5 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall got=%0d/%0b exp=5/0", binary, in_ready);
            end
        end
        tick(1, 1, 16'h0200, 1);
        #1;
        total++;
        if (binary !== 4'd9 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_next got=%0d/%0b exp=9/1", binary, out_valid); end
        tick(1, 0, 16'h0000, 1);
        total++;
        if (got_q.size() != 2 || got_q[0] !== 4'd5 || got_q[1] !== 4'd9) begin
            bad++;
            $display("FAIL stall_order got_n=%0d exp=5,9", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals[$];
        int sent = 0, budget = 0;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 16; i++) vals.push_back(4'((i + r * 5) % 16));
        got_q.delete();
        while (sent < vals.size() && budget < 1000) begin
            tick(1, 1, 16'd1 << vals[sent], 1'($urandom));
            if (last_acc) sent++;
            budget++;
        end
        total++;
        if (sent != vals.size()) begin bad++; $display("FAIL b2b_budget sent=%0d exp=%0d", sent, vals.size()); end
        repeat (2) tick(1, 0, 16'h0000, 1);
        total++;
        if (got_q.size() != vals.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), vals.size()); end
        else foreach (vals[i]) begin
            total++;
            if (got_q[i] !== vals[i]) begin bad++; $display("FAIL b2b[%0d] got=%0d exp=%0d", i, got_q[i], vals[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(3))
                0: w = 16'($urandom);
                1: w = 16'h0000;
                default: w = 16'd1 << $urandom_range(15);
            endcase
            tick(1, 1'($urandom), w, 1'($urandom));
        end
        tick(1, 0, 16'h0000, 1);
    endtask

    task automatic test_saturate();
        repeat (260) tick(1, 1, 16'h0000, 1);
        #1;
        total++;
        if (err_count !== 8'd255) begin bad++; $display("FAIL saturate got=%0d exp=255", err_count); end
        tick(1, 1, 16'h0000, 1);
        tick(0, 1, 16'h0000, 1);
        #1;
        total++;
        if (err_count !== 8'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=%0d/%0b exp=0/0", err_count, out_valid);
        end
        tick(1, 0, 16'h0000, 1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_malformed();
        test_stall();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
